mdu_ctrl: RTL
=============

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy cycles for MULT/MULTU (>=1).
REQ-002 Parameter DIV_CYCLES, default 10, busy cycles for DIV/DIVU (>=1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  E-stage MD instruction valid this cycle.
REQ-006 op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no-op.
REQ-007 src_a  input  32  forwarded rs operand.
REQ-008 src_b  input  32  forwarded rt operand.
REQ-009 req  input  1  exception/interrupt request; the E-stage instruction is being flushed.
REQ-010 busy  output  1  high while a multiply/divide is in flight; drives hazard stall.
REQ-011 hi  output  32  architectural HI.
REQ-012 lo  output  32  architectural LO.

Function
REQ-013 The block SHALL implement two states: IDLE and BUSY.
REQ-014 In IDLE, start=1 with req=0 and op in 0..3 SHALL latch the computed result into pending_hi/pending_lo, load the counter with MULT_CYCLES or DIV_CYCLES, and enter BUSY.
REQ-015 busy SHALL be high in every BUSY cycle and low in IDLE; busy SHALL NOT depend combinationally on start.
REQ-016 The counter SHALL decrement once per BUSY cycle; when it reaches 1, the next edge SHALL copy pending into hi/lo and return to IDLE.
REQ-017 Latency: busy SHALL be high for exactly MULT_CYCLES (or DIV_CYCLES) cycles, and hi/lo SHALL show the new result in the first cycle busy is low.
REQ-018 MULT SHALL produce the signed 64-bit product and MULTU the unsigned product: {hi,lo} = product.
REQ-019 DIV SHALL produce lo = signed quotient truncated toward zero and hi = remainder with the sign of the dividend; DIVU SHALL produce the unsigned quotient/remainder.
REQ-020 DIV/DIVU with src_b=0 SHALL still run DIV_CYCLES busy cycles and SHALL leave hi/lo unchanged at completion.
REQ-021 DIV with src_a=32'h80000000 and src_b=32'hFFFFFFFF SHALL yield lo=32'h80000000, hi=0.
REQ-022 MTHI/MTLO with start=1, req=0 in IDLE SHALL write src_a to hi/lo at the next edge without entering BUSY.
REQ-023 start=1 with req=1 SHALL be ignored: no state change, and no hi/lo write.
REQ-024 req asserted while BUSY SHALL NOT cancel the operation, because the issuing instruction has already retired past E.
REQ-025 start asserted while BUSY SHALL be ignored, because the hazard unit guarantees no MD issue while busy.
REQ-026 op 6/7 with start=1 SHALL have no effect.
REQ-027 hi/lo SHALL change only on completion per REQ-016 or on a move per REQ-022.

Reset
REQ-028 Reset low SHALL force IDLE, busy=0, hi=0, lo=0, counter=0 and pending=0, asynchronously.
REQ-029 Reset asserted mid-BUSY SHALL abandon the operation; hi/lo SHALL remain 0 after release.
REQ-030 The first edge after reset release SHALL accept start normally.

Verification
REQ-031 MULT src_a=32'hFFFFFFFE (-2), src_b=3 -> busy high 5 cycles, then hi=32'hFFFFFFFF, lo=32'hFFFFFFFA.
REQ-032 MULTU src_a=32'hFFFFFFFF, src_b=2 -> after 5 busy cycles, hi=1, lo=32'hFFFFFFFE.
REQ-033 DIV src_a=-7, src_b=2 -> busy high 10 cycles, then lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU 7/0 -> 10 busy cycles, hi/lo unchanged.
REQ-034 MTHI src_a=32'h12345678 with req=1 -> hi unchanged; repeated with req=0 -> hi=32'h12345678 next cycle, busy stays 0.
REQ-035 Start DIV, pulse req at busy cycle 3 and start MULT at cycle 4 -> DIV completes at cycle 10 with the DIV result; MULT is ignored.
REQ-036 Start MULT, assert reset low at busy cycle 2 -> busy=0 and hi=lo=0 immediately; they stay 0 after release.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: fixed-latency MULT/DIV with HI/LO architectural registers.
// Result is computed at issue and held in pending until the busy countdown expires.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        req,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [31:0]   r_pend_hi, r_pend_lo, w_pend_hi_nxt, w_pend_lo_nxt;
    logic [31:0]   r_hi, r_lo, w_hi_nxt, w_lo_nxt;

    logic [63:0]   w_prod_u, w_prod_s;
    logic [31:0]   w_div_b, w_abs_a, w_abs_b, w_sq, w_sr;
    logic [31:0]   w_sdiv_q, w_sdiv_r, w_udiv_q, w_udiv_r;
    logic          w_b_zero, w_issue;

    assign w_prod_u = {32'b0, src_a} * {32'b0, src_b};
    assign w_prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});

    // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
    assign w_b_zero = (src_b == 32'd0);
    assign w_div_b  = w_b_zero ? 32'd1 : src_b;
    assign w_abs_a  = src_a[31] ? (32'd0 - src_a) : src_a;
    assign w_abs_b  = src_b[31] ? (32'd0 - src_b) : w_div_b;
    assign w_sq     = w_abs_a / w_abs_b;
    assign w_sr     = w_abs_a % w_abs_b;
    assign w_sdiv_q = (src_a[31] ^ src_b[31]) ? (32'd0 - w_sq) : w_sq;
    assign w_sdiv_r = src_a[31] ? (32'd0 - w_sr) : w_sr;
    assign w_udiv_q = src_a / w_div_b;
    assign w_udiv_r = src_a % w_div_b;

    assign w_issue  = (r_state == IDLE) && start && !req;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        case (r_state)
            IDLE: begin
                if (w_issue) begin
                    case (op)
                        3'd0: begin
                            {w_pend_hi_nxt, w_pend_lo_nxt} = w_prod_s;
                            w_cnt_nxt   = CW'(MULT_CYCLES);
                            w_state_nxt = BUSY;
                        end
                        3'd1: begin
                            {w_pend_hi_nxt, w_pend_lo_nxt} = w_prod_u;
                            w_cnt_nxt   = CW'(MULT_CYCLES);
                            w_state_nxt = BUSY;
                        end
                        3'd2, 3'd3: begin
                            // Divide by zero re-commits the current HI/LO, leaving them unchanged.
                            if (w_b_zero) begin
                                w_pend_hi_nxt = r_hi;
                                w_pend_lo_nxt = r_lo;
                            end else if (op == 3'd2) begin
                                w_pend_hi_nxt = w_sdiv_r;
                                w_pend_lo_nxt = w_sdiv_q;
                            end else begin
                                w_pend_hi_nxt = w_udiv_r;
                                w_pend_lo_nxt = w_udiv_q;
                            end
                            w_cnt_nxt   = CW'(DIV_CYCLES);
                            w_state_nxt = BUSY;
                        end
                        3'd4:    w_hi_nxt = src_a;
                        3'd5:    w_lo_nxt = src_a;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                if (r_cnt == CW'(1)) begin
                    w_hi_nxt    = r_pend_hi;
                    w_lo_nxt    = r_pend_lo;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
        end
    end

    assign busy = (r_state == BUSY);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
